sipo_deserializer: RTL and testbench

Serial-in parallel-out front end that assembles a serial bitstream into WIDTH-bit words for the downstream PIPO register.
- Drives the PIPO parallel inputs from d_out[WIDTH-1:0].
- Drives the PIPO load input from the load pulse.
- The PIPO captures a word on the clock edge where load is high. It applies no backpressure, so this block never stalls.

---
 rtl/sipo_deserializer.sv | 125 ++++++++++++
 tb/tb_sipo_deserializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer feeding a PIPO register; one word per WIDTH valid bits.
// Optional even-parity bit after each word when PARITY_CHECK_EN is defined.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] d_out,
    output logic             load,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [IW-1:0] P0   = (MSB_FIRST != 0) ? IW'(WIDTH - 1) : IW'(0);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d, dout_d;
    logic [WIDTH-1:0] word, first;
    logic [IW-1:0]    pos;
    logic             load_d, ferr_d, perr_d;

    // Bit position of the cnt-th received bit, mirrored when MSB arrives first
    assign pos = (MSB_FIRST != 0) ? (IW'(WIDTH - 1) - cnt_q[IW-1:0]) : cnt_q[IW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dout_d  = d_out;
        load_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        word    = buf_q;
        word[pos] = ser_in;
        first   = '0;
        first[P0] = ser_in;
        if (ser_valid) begin
            case (state_q)
                IDLE: begin
                    buf_d   = first;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (sof) begin
                        ferr_d = 1'b1;
                        buf_d  = first;
                        cnt_d  = CW'(1);
                    end else if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        buf_d   = word;
                        state_d = PARITY;
`else
                        buf_d   = '0;
                        dout_d  = word;
                        load_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        buf_d = word;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    if (sof) begin
                        ferr_d  = 1'b1;
                        buf_d   = first;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        // Even parity: data bits XOR parity bit must be zero
                        if ((^buf_q ^ ser_in) == 1'b0) begin
                            dout_d = buf_q;
                            load_d = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
                        buf_d   = '0;
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            d_out      <= '0;
            load       <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            d_out      <= dout_d;
            load       <= load_d;
            busy       <= (state_d != IDLE);
            frame_err  <= ferr_d;
            parity_err <= perr_d;
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: LSB-first and MSB-first instances share one stimulus stream.
module tb_sipo_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_in = 1'b0, ser_valid = 1'b0, sof = 1'b0;
    logic [3:0] d0, d1;
    logic       load0, busy0, ferr0, perr0;
    logic       load1, busy1, ferr1, perr1;
    int         n_chk = 0;
    int         n_fail = 0;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .sof(sof),
        .d_out(d0), .load(load0), .busy(busy0), .frame_err(ferr0), .parity_err(perr0));

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .sof(sof),
        .d_out(d1), .load(load1), .busy(busy1), .frame_err(ferr1), .parity_err(perr1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic v, input logic b, input logic s);
        ser_valid = v;
        ser_in    = b;
        sof       = s;
        @(posedge clk);
        #1;
    endtask

    // Parity bit following a word; absent in the default build
    task automatic par(input logic p);
`ifdef PARITY_CHECK_EN
        cyc(1'b1, p, 1'b0);
`else
        chk("no_parity_err", {15'd0, perr0}, 16'd0);
        if (p === 1'bx) chk("par_arg", 16'd0, 16'd1);
`endif
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", {12'd0, d0}, 16'h0);
        chk("rst_load", {15'd0, load0}, 16'd0);
        chk("rst_busy", {15'd0, busy0}, 16'd0);
        #4 rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk("idle_busy", {15'd0, busy0}, 16'd0);

        // Basic word 1,0,1,1
        cyc(1'b1, 1'b1, 1'b0);
        chk("w1_busy", {15'd0, busy0}, 16'd1);
        chk("w1_load_b0", {15'd0, load0}, 16'd0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("w1_load_b2", {15'd0, load0}, 16'd0);
        cyc(1'b1, 1'b1, 1'b0);
        par(1'b1);
        chk("w1_load", {15'd0, load0}, 16'd1);
        chk("w1_dout_lsb", {12'd0, d0}, 16'hD);
        chk("w1_dout_msb", {12'd0, d1}, 16'hB);
        chk("w1_load_msb", {15'd0, load1}, 16'd1);
        chk("w1_busy_end", {15'd0, busy0}, 16'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("w1_load_drop", {15'd0, load0}, 16'd0);
        chk("w1_dout_hold", {12'd0, d0}, 16'hD);

        // Gap mid-word: 0,1, three idles, 1,0
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("gap_busy", {15'd0, busy0}, 16'd1);
            chk("gap_load", {15'd0, load0}, 16'd0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        par(1'b0);
        chk("gap_load_end", {15'd0, load0}, 16'd1);
        chk("gap_dout_lsb", {12'd0, d0}, 16'h6);
        chk("gap_dout_msb", {12'd0, d1}, 16'h6);

        // Back-to-back 1,1,1,1
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("b2b_noload", {15'd0, load0}, 16'd0);
            chk("b2b_dout_hold", {12'd0, d0}, 16'h6);
        end
        cyc(1'b1, 1'b1, 1'b0);
        par(1'b0);
        chk("b2b_load", {15'd0, load0}, 16'd1);
        chk("b2b_dout", {12'd0, d0}, 16'hF);

        // sof abort: 1,1 then sof with 1, then 0,0,1
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("sof_ferr", {15'd0, ferr0}, 16'd1);
        chk("sof_noload", {15'd0, load0}, 16'd0);
        chk("sof_busy", {15'd0, busy0}, 16'd1);
        chk("sof_dout_hold", {12'd0, d0}, 16'hF);
        cyc(1'b1, 1'b0, 1'b0);
        chk("sof_ferr_drop", {15'd0, ferr0}, 16'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("sof_noload2", {15'd0, load0}, 16'd0);
        cyc(1'b1, 1'b1, 1'b0);
        par(1'b0);
        chk("sof_load", {15'd0, load0}, 16'd1);
        chk("sof_dout_lsb", {12'd0, d0}, 16'h9);
        chk("sof_dout_msb", {12'd0, d1}, 16'h9);

        // Asynchronous reset mid-word, then a fresh word
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        ser_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", {12'd0, d0}, 16'h0);
        chk("arst_busy", {15'd0, busy0}, 16'd0);
        chk("arst_load", {15'd0, load0}, 16'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("arst_noload", {15'd0, load0}, 16'd0);
            chk("arst_dout_zero", {12'd0, d0}, 16'h0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        par(1'b0);
        chk("arst_load_end", {15'd0, load0}, 16'd1);
        chk("arst_dout_end", {12'd0, d0}, 16'hF);
        cyc(1'b0, 1'b0, 1'b0);
        chk("arst_hold", {12'd0, d0}, 16'hF);

`ifdef PARITY_CHECK_EN
        // Good parity loads; bad parity pulses parity_err and keeps d_out
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("par_wait", {15'd0, load0}, 16'd0);
        chk("par_busy", {15'd0, busy0}, 16'd1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("par_ok_load", {15'd0, load0}, 16'd1);
        chk("par_ok_dout", {12'd0, d0}, 16'hD);
        chk("par_ok_perr", {15'd0, perr0}, 16'd0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("par_bad_perr", {15'd0, perr0}, 16'd1);
        chk("par_bad_noload", {15'd0, load0}, 16'd0);
        chk("par_bad_dout", {12'd0, d0}, 16'hD);
        cyc(1'b0, 1'b0, 1'b0);
        chk("par_perr_drop", {15'd0, perr0}, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
